// File: rtl/hyperbus_mem_model_multi.sv
// hyperbus_mem_model_multi: cycle-based multi-chip HyperBus memory model.
// Optional byte counters: define HYPER_MODEL_STATS_EN.
module hyperbus_mem_model_multi #(
    parameter int unsigned NumChips = 2,
    parameter int unsigned MemWords = 65536,
    parameter logic [15:0] IdValue  = 16'h0C81,
    parameter logic [15:0] ResetCr0 = 16'h8F1F
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NumChips-1:0] cs_ni,
    input  logic                ck_i,
    input  logic [7:0]          dq_i,
    output logic [7:0]          dq_o,
    output logic                dq_oe_o,
    input  logic                rwds_i,
    output logic                rwds_o,
    output logic                rwds_oe_o,
    output logic                cs_err_o,
    output logic [31:0]         rd_bytes_o,
    output logic [31:0]         wr_bytes_o
);

    localparam int unsigned AW = $clog2(MemWords);
    localparam int unsigned SW = (NumChips > 1) ? $clog2(NumChips) : 1;
    localparam logic [31:0] AddrMask = 32'(MemWords - 1);
    localparam logic [31:0] Cr0Addr  = 32'h0000_0800;

    typedef enum logic [2:0] {
        IDLE,
        CA,
        LAT,
        RD,
        WR,
        REGWR,
        DONE
    } state_e;

    state_e st_q, st_d;

    logic          ck_q;
    logic          ck_edge;
    logic [7:0]    cnt_q;
    logic          phase_q;
    logic [39:0]   ca_q;
    logic [47:0]   ca_nx;
    logic [31:0]   ca_addr;
    logic          ca_unused;
    logic [31:0]   addr_q;
    logic [AW-1:0] maddr;
    logic          is_rd_q;
    logic          is_reg_q;
    logic [7:0]    wbuf_q;
    logic [SW-1:0] sel;
    logic [SW-1:0] sel_q;
    logic          cs_multi;
    logic          cs_none;
    logic          act;
    logic [7:0]    lat_w;
    logic [15:0]   rdata;
    logic          wr_hi;
    logic          wr_lo;

    logic [7:0]    dq_d;
    logic          dq_oe_d;
    logic          rwds_d;
    logic          rwds_oe_d;

    logic [15:0]   cr0_q [NumChips];
    logic [15:0]   mem [NumChips][MemWords];

    // Initial latency in CK edges from a CR0 value.
    function automatic logic [7:0] lat_edges(input logic [15:0] cr);
        logic [7:0] l;
        unique case (cr[7:4])
            4'd0:    l = 8'd5;
            4'd1:    l = 8'd6;
            4'd2:    l = 8'd7;
            4'd14:   l = 8'd3;
            4'd15:   l = 8'd4;
            default: l = 8'd6;
        endcase
        return cr[3] ? (l << 2) : (l << 1);
    endfunction

    assign ck_edge  = ck_i != ck_q;
    assign cs_multi = $countones(~cs_ni) > 1;
    assign cs_none  = &cs_ni;
    assign act      = !cs_multi && !cs_none;

    assign ca_nx     = {ca_q, dq_i};
    assign ca_addr   = {ca_nx[44:16], ca_nx[2:0]};
    assign ca_unused = ^{ca_nx[45], ca_nx[15:3]};

    assign maddr = addr_q[AW-1:0];
    assign lat_w = lat_edges(cr0_q[sel_q]);

    assign wr_hi = !rst_i && act && ck_edge && st_q == WR
                   && !phase_q && !rwds_i;
    assign wr_lo = !rst_i && act && ck_edge && st_q == WR
                   && phase_q && !rwds_i;

    // Index of the (single) low chip select.
    always_comb begin
        sel = '0;
        for (int i = 0; i < NumChips; i++) begin
            if (!cs_ni[i]) sel = SW'(i);
        end
    end

    // Read word source: memory array or register space.
    always_comb begin
        rdata = mem[sel_q][maddr];
        if (is_reg_q) begin
            if (addr_q == 32'd0) begin
                rdata = IdValue;
            end else if (addr_q == Cr0Addr) begin
                rdata = cr0_q[sel_q];
            end else begin
                rdata = 16'h0000;
            end
        end
    end

    // Next state and next registered pad outputs.
    always_comb begin
        st_d      = st_q;
        dq_d      = dq_o;
        dq_oe_d   = dq_oe_o;
        rwds_d    = rwds_o;
        rwds_oe_d = rwds_oe_o;
        if (!act) begin
            st_d      = IDLE;
            dq_d      = '0;
            dq_oe_d   = 1'b0;
            rwds_d    = 1'b0;
            rwds_oe_d = 1'b0;
        end else begin
            unique case (st_q)
                IDLE: begin
                    st_d      = CA;
                    dq_d      = '0;
                    dq_oe_d   = 1'b0;
                    rwds_oe_d = 1'b1;
                    rwds_d    = cr0_q[sel][3];
                end
                CA: begin
                    if (ck_edge && cnt_q == 8'd5) begin
                        rwds_d = 1'b0;
                        if (ca_nx[46] && !ca_nx[47]) begin
                            st_d      = REGWR;
                            rwds_oe_d = 1'b0;
                        end else begin
                            st_d      = LAT;
                            rwds_oe_d = ca_nx[47];
                        end
                    end
                end
                LAT: begin
                    if (ck_edge && cnt_q == lat_w - 8'd1) begin
                        st_d = is_rd_q ? RD : WR;
                    end
                end
                RD: begin
                    dq_oe_d   = 1'b1;
                    rwds_oe_d = 1'b1;
                    if (ck_edge) begin
                        dq_d   = phase_q ? rdata[7:0] : rdata[15:8];
                        rwds_d = !phase_q;
                    end
                end
                REGWR: begin
                    dq_oe_d   = 1'b0;
                    rwds_oe_d = 1'b0;
                    if (ck_edge && phase_q) st_d = DONE;
                end
                WR, DONE: begin
                    dq_oe_d   = 1'b0;
                    rwds_oe_d = 1'b0;
                end
                default: st_d = IDLE;
            endcase
        end
    end

    // State and pad output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            st_q      <= IDLE;
            dq_o      <= '0;
            dq_oe_o   <= 1'b0;
            rwds_o    <= 1'b0;
            rwds_oe_o <= 1'b0;
        end else begin
            st_q      <= st_d;
            dq_o      <= dq_d;
            dq_oe_o   <= dq_oe_d;
            rwds_o    <= rwds_d;
            rwds_oe_o <= rwds_oe_d;
        end
    end

    // Command decode, counters, address and CR0 registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ck_q     <= 1'b0;
            cnt_q    <= '0;
            phase_q  <= 1'b0;
            ca_q     <= '0;
            addr_q   <= '0;
            is_rd_q  <= 1'b0;
            is_reg_q <= 1'b0;
            wbuf_q   <= '0;
            sel_q    <= '0;
            cs_err_o <= 1'b0;
            for (int i = 0; i < NumChips; i++) begin
                cr0_q[i] <= ResetCr0;
            end
        end else begin
            ck_q <= ck_i;
            if (cs_multi) cs_err_o <= 1'b1;
            if (act) begin
                unique case (st_q)
                    IDLE: begin
                        sel_q   <= sel;
                        cnt_q   <= '0;
                        phase_q <= 1'b0;
                    end
                    CA: begin
                        if (ck_edge) begin
                            ca_q  <= ca_nx[39:0];
                            cnt_q <= cnt_q + 8'd1;
                            if (cnt_q == 8'd5) begin
                                cnt_q    <= '0;
                                is_rd_q  <= ca_nx[47];
                                is_reg_q <= ca_nx[46];
                                addr_q   <= ca_nx[46] ? ca_addr
                                            : (ca_addr & AddrMask);
                            end
                        end
                    end
                    LAT: begin
                        if (ck_edge) cnt_q <= cnt_q + 8'd1;
                    end
                    RD, WR: begin
                        if (ck_edge) begin
                            phase_q <= !phase_q;
                            if (phase_q && !is_reg_q) begin
                                addr_q <= (addr_q + 32'd1) & AddrMask;
                            end
                        end
                    end
                    REGWR: begin
                        if (ck_edge) begin
                            phase_q <= !phase_q;
                            if (!phase_q) begin
                                wbuf_q <= dq_i;
                            end else if (addr_q == Cr0Addr) begin
                                cr0_q[sel_q] <= {wbuf_q, dq_i};
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Memory arrays, byte-granular writes, never reset.
    always_ff @(posedge clk_i) begin
        if (wr_hi) mem[sel_q][maddr][15:8] <= dq_i;
        if (wr_lo) mem[sel_q][maddr][7:0]  <= dq_i;
    end

`ifdef HYPER_MODEL_STATS_EN
    logic rd_stb;
    assign rd_stb = act && ck_edge && st_q == RD;

    // Saturating read and committed-write byte counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_bytes_o <= '0;
            wr_bytes_o <= '0;
        end else begin
            if (rd_stb && rd_bytes_o != '1) begin
                rd_bytes_o <= rd_bytes_o + 32'd1;
            end
            if ((wr_hi || wr_lo) && wr_bytes_o != '1) begin
                wr_bytes_o <= wr_bytes_o + 32'd1;
            end
        end
    end
`else
    assign rd_bytes_o = '0;
    assign wr_bytes_o = '0;
`endif

endmodule

// File: doc/hyperbus_mem_model_multi.md
Name: hyperbus_mem_model_multi

Overview:
- Parametrised, cycle-based HyperBus memory device model for the chip-level simulation fixture.
- Serves NumChips chip selects on one PHY from a single oversampling clock.
- Replaces the single-chip timing model in fixtures where SDF annotation is unnecessary.
- Detects CK edges by oversampling, decodes the 48-bit command/address, and applies configurable initial latency. Supports linear bursts, byte masking and CR0/ID0 register access.

Parameters:
- NumChips, 2, number of chip selects / independent memory arrays.
- MemWords, 65536, 16-bit words per chip; must be a power of two.
- IdValue, 16'h0C81, value returned for ID0 register reads.
- ResetCr0, 16'h8F1F, CR0 reset value.

Ports:
- clk_i  in  1  oversampling clock; must be ≥4× HyperBus CK.
- rst_i  in  1  synchronous active-high reset.
- cs_ni  in  NumChips  chip selects, active low.
- ck_i  in  1  HyperBus CK; CK# is not modelled.
- dq_i  in  8  DQ from host.
- dq_o  out  8  DQ driven by model.
- dq_oe_o  out  1  DQ output enable.
- rwds_i  in  1  RWDS from host; write mask.
- rwds_o  out  1  RWDS driven by model.
- rwds_oe_o  out  1  RWDS output enable.
- cs_err_o  out  1  more than one cs_ni low, sticky.
- rd_bytes_o  out  32  bytes read (optional feature).
- wr_bytes_o  out  32  bytes written (optional feature).

Behaviour:
- Reset values:
  - All outputs 0.
  - FSM = IDLE; CR0 = ResetCr0 for every chip.
  - Memory contents are not reset.
- Edge detection:
  - ck_q registered each cycle; edge = ck_i != ck_q.
  - All dq_i and rwds_i sampling happens in the edge cycle.
  - Outputs update on the cycle after an edge (1-cycle registered latency).
- Chip select:
  - sel = index of the single low cs_ni bit.
  - Two or more low bits: cs_err_o sets to 1 until reset; FSM forced to IDLE; outputs released.
- Abort: all cs_ni high in any state → IDLE next cycle, dq_oe_o=rwds_oe_o=0. Partially received words are discarded; already-committed bytes remain.
- IDLE: on a valid single select → CA, edge count 0. rwds_oe_o=1, rwds_o=CR0[3] of the selected chip.
- CA:
  - Shift in 6 bytes, MSB first, one per edge.
  - CA[47]=read, CA[46]=register space, CA[45] ignored (linear only).
  - Word address = {CA[44:16],CA[2:0]} modulo MemWords.
- CA exit:
  - Register write → REGWR, zero latency.
  - Otherwise → LAT with W = CR0[3] ? 4L : 2L edges, where L comes from CR0[7:4]: 0→5, 1→6, 2→7, 14→3, 15→4, others→6.
- LAT:
  - Count W edges, then → RD or WR.
  - rwds_oe_o=1 and rwds_o=0 for reads; rwds_oe_o=0 for writes.
- RD:
  - Per word, edge 1: dq_o=word[15:8], rwds_o=1.
  - Edge 2: dq_o=word[7:0], rwds_o=0; address then increments and wraps MemWords-1 → 0.
  - dq_oe_o=rwds_oe_o=1.
  - Register read: address 0 → IdValue, 0x800 → CR0, others → 0; register address does not increment.
- WR:
  - Edge 1 captures the upper byte, edge 2 the lower byte.
  - Each byte is committed immediately unless rwds_i=1 at that edge (masked).
  - Address increments after edge 2 with the same wrap rule.
- REGWR:
  - Two edges capture the word (upper byte first); written only if address = 0x800, else dropped; no masking.
  - Then DONE.
- DONE: ignore edges until cs_ni all high.

Optional Feature:
- Macro: HYPER_MODEL_STATS_EN.
- Defined:
  - rd_bytes_o counts RD-state bytes, memory and register.
  - wr_bytes_o counts committed unmasked memory bytes.
  - Both counters are saturating, reset to 0.
- Undefined: both ports tied to 0, no counter logic.

Test Plan:
- Reset, preload chip0 word 0x10=16'hBEEF; read 1 word at 0x10 with CR0 default → RWDS high during CA, 24 edges latency, dq_o=8'hBE then 8'hEF, rwds_o 1 then 0.
- Register write CR0=16'h8FE7 (L=3, fixed latency off) on chip1, then read word 0 → latency 6 edges; chip0 still 24.
- Write 2 words 16'h1234,16'h5678 at 0x20 with rwds_i=1 on byte 3 → memory holds 16'h1234, 16'h??78 (upper byte unchanged).
- Read burst of 3 words from MemWords-1 → returns words MemWords-1, 0, 1.
- cs_ni=2'b00 mid-burst → cs_err_o=1 next cycle, outputs released; cs_ni deassert mid-read → IDLE, dq_oe_o=0 one cycle later.
- With HYPER_MODEL_STATS_EN: 4-byte read and 4-byte write with one masked byte → rd_bytes_o=4, wr_bytes_o=3; without macro both stay 0.
